periph_bus_fabric: RTL and testbench
====================================

// Module: periph_bus_fabric
// PURPOSE
//  Parametrised memory-mapped peripheral interconnect between core data bus and N peripheral slots.
//  Generalises the fixed 4-slot decoder/mux: configurable slot count, per-slot ready handshake (wait states),
//  registered read data, bus error on unmapped/misaligned access, access timeout.
//  Sits between the core's peripheral-region port and digital_in/digital_out/timer/7-seg-style peripherals.
// PARAMETERS
//  N_SLOTS   8    number of peripheral slots; slot k occupies word address 4*k
//  ADDR_W    6    master address width (bytes); must satisfy 2^(ADDR_W-2) >= N_SLOTS
//  DATA_W    32   data width of master and slave buses
//  TIMEOUT   15   max ACCESS cycles waiting for s_ready; 0 = no timeout (wait forever)
// PORTS
//  clk      in   1               system clock, all logic on rising edge
//  rst      in   1               synchronous reset, active-high
//  A        in   ADDR_W          master byte address
//  WD       in   DATA_W          master write data
//  WE       in   1               master write request
//  RE       in   1               master read request
//  RD       out  DATA_W          registered read data
//  ready    out  1               one-cycle transaction-complete pulse
//  err      out  1               valid with ready; 1 = unmapped, misaligned or timed out
//  s_sel    out  N_SLOTS         one-hot slot select, held for whole ACCESS
//  s_we     out  1               slave write strobe (qualified by s_sel)
//  s_re     out  1               slave read strobe (qualified by s_sel)
//  s_wd     out  DATA_W          latched write data to slaves
//  s_rd     in   N_SLOTS*DATA_W  slave read data, slot k at [k*DATA_W +: DATA_W]
//  s_ready  in   N_SLOTS         per-slot ready; only selected slot's bit is honoured
// BEHAVIOUR
//  - Reset: state IDLE; RD=0, ready=0, err=0, s_sel=0, s_we=0, s_re=0, s_wd=0, timeout counter=0.
//  - Reset mid-transaction: transaction abandoned, no ready pulse, strobes drop next cycle.
//  - Decode: slot = A[ADDR_W-1:2]; hit = slot < N_SLOTS; misaligned = A[1:0] != 0.
//  - FSM IDLE: req = WE|RE. On req, latch slot, WD->s_wd, op (WE wins if WE&RE both high).
//    hit & aligned -> ACCESS; else -> RESP with err=1, no slave strobe issued, RD forced 0 on read.
//  - ACCESS: s_sel[slot]=1, s_we or s_re=1 every cycle. Counter increments each cycle.
//    s_ready[slot]=1 -> on read capture s_rd slot into RD; -> RESP err=0.
//    counter reaches TIMEOUT (TIMEOUT!=0) without ready -> RESP err=1, RD=0 on read. Ready wins over timeout on same cycle.
//  - RESP: ready=1 for exactly one cycle, err valid; strobes/s_sel low; -> IDLE. counter cleared.
//  - Latency: request in cycle n, zero-wait slave -> ready high in cycle n+2. Each wait state adds one cycle.
//  - Master requests outside IDLE ignored (master holds until ready). Writes never alter RD; RD holds last read value.
// CONFIGURATION
//  PERIPH_BUS_ERRLOG_EN defined: adds outputs err_addr[ADDR_W] and err_code[2] (01 unmapped, 10 misaligned,
//   11 timeout), captured on first error and sticky; cleared by write of any value to
//   byte address 4*N_SLOTS (itself not an error, ready err=0). Undefined: ports absent, 4*N_SLOTS is unmapped.
// STRUCTURE
//  Shared package periph_bus_pkg: FSM state encoding (IDLE/ACCESS/RESP), err_code constants, slot-index width helper.
//  Sub-module periph_addr_decode: combinational A -> {slot index, hit, misaligned}; reused by future bridges.
// TESTING
//  1 Read slot 2, s_ready[2] high immediately, s_rd slot2=0xDEADBEEF -> ready at n+2, err=0, RD=0xDEADBEEF.
//  2 Write 0x1234 to A=0x0C, slot 3 holds ready low 3 cycles -> s_sel=0b1000, s_we 4 cycles, ready n+5, RD unchanged.
//  3 Read A=0x20 (slot 8, N_SLOTS=8) -> no strobe, ready n+2, err=1, RD=0.
//  4 Read A=0x05 -> misaligned, err=1, no s_sel; with ERRLOG: err_code=10, err_addr=0x05.
//  5 Read slot 1 never ready, TIMEOUT=15 -> ready err=1 after 15 ACCESS cycles, RD=0; ERRLOG code 11.
//  6 rst asserted during ACCESS of wait-state write -> s_sel/s_we 0 next cycle, no ready; new read succeeds after.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus fabric: FSM state encoding,
// error-log codes and an index-width helper.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_t;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED   = 2'b01;
  localparam logic [1:0] ERR_MISALIGNED = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b11;

  // Bits needed to index n items; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/periph_addr_decode.sv
// Combinational byte-address decoder: word slot index, in-range hit and
// misalignment flag. Kept standalone so bridges can reuse it.
module periph_addr_decode
  import periph_bus_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int N_SLOTS = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-3:0] slot,
  output logic              hit,
  output logic              misaligned
);

  // Slot k lives at word address 4*k; anything beyond the last slot is unmapped.
  always_comb begin
    slot       = addr[ADDR_W-1:2];
    hit        = (32'(addr[ADDR_W-1:2]) < 32'(N_SLOTS));
    misaligned = (addr[1:0] != 2'b00);
  end

endmodule

// File: rtl/periph_bus_fabric.sv
// Peripheral bus fabric: decodes the core's peripheral-region access onto one
// of N_SLOTS slave slots, waits for the slot's ready, registers read data and
// returns a one-cycle ready pulse with an error flag.
//
// Handshake: a master request (WE or RE) is sampled only in IDLE and the
// master holds it until ready; ready is a single-cycle pulse with err valid in
// the same cycle. Toward slaves, s_sel/s_we/s_re stay high for every ACCESS
// cycle until the selected slot raises its s_ready bit; other s_ready bits
// are ignored.
//
// Rejected requests (unmapped, misaligned) still spend one strobe-free cycle
// in ACCESS, so every response arrives no earlier than two cycles after the
// request.
//
// Optional feature: define PERIPH_BUS_ERRLOG_EN to add the sticky error log
// (err_addr/err_code), cleared by a write to byte address 4*N_SLOTS.
module periph_bus_fabric
  import periph_bus_pkg::*;
#(
  parameter int N_SLOTS = 8,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_W-1:0]         A,
  input  logic [DATA_W-1:0]         WD,
  input  logic                      WE,
  input  logic                      RE,
  output logic [DATA_W-1:0]         RD,
  output logic                      ready,
  output logic                      err,
  output logic [N_SLOTS-1:0]        s_sel,
  output logic                      s_we,
  output logic                      s_re,
  output logic [DATA_W-1:0]         s_wd,
  input  logic [N_SLOTS*DATA_W-1:0] s_rd,
  input  logic [N_SLOTS-1:0]        s_ready,
`ifdef PERIPH_BUS_ERRLOG_EN
  output logic [ADDR_W-1:0]         err_addr,
  output logic [1:0]                err_code,
`endif
  output logic [1:0]                fsm_state
);

  localparam int SLOT_W = idx_width(N_SLOTS);
  localparam int CNT_W  = idx_width(TIMEOUT + 1);

  bus_state_t        state;
  logic [ADDR_W-3:0] dec_slot;
  logic              dec_hit;
  logic              dec_mis;
  logic [SLOT_W-1:0] slot_q;
  logic              op_write;
  logic [1:0]        pend_code;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rd_sel;
  logic              sel_ready;
  logic              done;
  logic [1:0]        done_code;

`ifdef PERIPH_BUS_ERRLOG_EN
  logic [ADDR_W-1:0] addr_q;
  logic              clr_q;
  logic              clr_hit;
`endif

  periph_addr_decode #(
    .ADDR_W  (ADDR_W),
    .N_SLOTS (N_SLOTS)
  ) u_decode (
    .addr       (A),
    .slot       (dec_slot),
    .hit        (dec_hit),
    .misaligned (dec_mis)
  );

  assign fsm_state = state;

`ifdef PERIPH_BUS_ERRLOG_EN
  // The word just past the last slot is the error-log clear register.
  assign clr_hit = WE && !dec_mis && (32'(dec_slot) == 32'(N_SLOTS));
`endif

  // Read data and ready of the latched slot.
  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (slot_q == SLOT_W'(k)) rd_sel = s_rd[k*DATA_W +: DATA_W];
    end
    sel_ready = s_ready[slot_q];
  end

  // Decide whether ACCESS ends this cycle and with which outcome; ready wins over timeout.
  always_comb begin
    done      = 1'b0;
    done_code = ERR_NONE;
    if (pend_code != ERR_NONE) begin
      done      = 1'b1;
      done_code = pend_code;
    end
`ifdef PERIPH_BUS_ERRLOG_EN
    else if (clr_q) begin
      done = 1'b1;
    end
`endif
    else if (sel_ready) begin
      done = 1'b1;
    end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
      done      = 1'b1;
      done_code = ERR_TIMEOUT;
    end
  end

  // Transaction FSM with registered master and slave-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      RD        <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      s_sel     <= '0;
      s_we      <= 1'b0;
      s_re      <= 1'b0;
      s_wd      <= '0;
      cnt       <= '0;
      slot_q    <= '0;
      op_write  <= 1'b0;
      pend_code <= ERR_NONE;
`ifdef PERIPH_BUS_ERRLOG_EN
      addr_q    <= '0;
      clr_q     <= 1'b0;
      err_addr  <= '0;
      err_code  <= ERR_NONE;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (WE || RE) begin
            state    <= ST_ACCESS;
            s_wd     <= WD;
            op_write <= WE;
            slot_q   <= dec_slot[SLOT_W-1:0];
            cnt      <= '0;
`ifdef PERIPH_BUS_ERRLOG_EN
            addr_q   <= A;
            clr_q    <= 1'b0;
`endif
            if (dec_mis) begin
              pend_code <= ERR_MISALIGNED;
            end
`ifdef PERIPH_BUS_ERRLOG_EN
            else if (clr_hit) begin
              pend_code <= ERR_NONE;
              clr_q     <= 1'b1;
            end
`endif
            else if (!dec_hit) begin
              pend_code <= ERR_UNMAPPED;
            end else begin
              pend_code <= ERR_NONE;
              s_sel     <= N_SLOTS'(1) << dec_slot;
              s_we      <= WE;
              s_re      <= !WE;
            end
          end
        end

        ST_ACCESS: begin
          if (done) begin
            state <= ST_RESP;
            ready <= 1'b1;
            err   <= (done_code != ERR_NONE);
            s_sel <= '0;
            s_we  <= 1'b0;
            s_re  <= 1'b0;
            cnt   <= '0;
            if (!op_write) RD <= (done_code == ERR_NONE) ? rd_sel : '0;
`ifdef PERIPH_BUS_ERRLOG_EN
            if (clr_q) begin
              err_code <= ERR_NONE;
              err_addr <= '0;
            end else if ((done_code != ERR_NONE) && (err_code == ERR_NONE)) begin
              err_code <= done_code;
              err_addr <= addr_q;
            end
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus_fabric.sv
// Directed bench for periph_bus_fabric with a per-slot wait-state slave model.
module tb_periph_bus_fabric;

  localparam int N   = 8;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int TMO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [AW-1:0]   A;
  logic [DW-1:0]   WD;
  logic            WE, RE;
  logic [DW-1:0]   RD;
  logic            ready, err;
  logic [N-1:0]    s_sel;
  logic            s_we, s_re;
  logic [DW-1:0]   s_wd;
  logic [N*DW-1:0] s_rd;
  logic [N-1:0]    s_ready;
  logic [1:0]      fsm_state;
`ifdef PERIPH_BUS_ERRLOG_EN
  logic [AW-1:0]   err_addr;
  logic [1:0]      err_code;
`endif

  periph_bus_fabric #(
    .N_SLOTS (N),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .WD        (WD),
    .WE        (WE),
    .RE        (RE),
    .RD        (RD),
    .ready     (ready),
    .err       (err),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_re      (s_re),
    .s_wd      (s_wd),
    .s_rd      (s_rd),
    .s_ready   (s_ready),
`ifdef PERIPH_BUS_ERRLOG_EN
    .err_addr  (err_addr),
    .err_code  (err_code),
`endif
    .fsm_state (fsm_state)
  );

  // ---------------- slave model ----------------
  // Selected slot raises ready after wait_cfg[k] ACCESS cycles; unselected
  // slots drive ready high so a wrong-bit decode is visible.
  int wait_cfg [N];
  int acc_cyc = 0;

  always @(posedge clk) acc_cyc <= (|s_sel) ? acc_cyc + 1 : 0;

  always_comb begin
    s_ready = '0;
    for (int k = 0; k < N; k++) begin
      s_ready[k] = s_sel[k] ? (acc_cyc >= wait_cfg[k]) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- driver ----------------
  int            r_lat, r_we, r_re;
  logic          r_err;
  logic [DW-1:0] r_rd;
  logic [N-1:0]  r_sel;

  // Issue one request held for a single cycle, then watch until ready.
  // r_lat counts cycles after the request cycle: ready in cycle n+r_lat.
  task automatic run(input logic wr, input logic rdq, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wd);
    A = addr; WD = wd; WE = wr; RE = rdq;
    @(posedge clk); #1;
    WE = 1'b0; RE = 1'b0;
    r_lat = 1; r_sel = '0; r_we = 0; r_re = 0;
    while (!ready && r_lat < 100) begin
      r_sel |= s_sel;
      r_we  += int'(s_we);
      r_re  += int'(s_re);
      @(posedge clk); #1;
      r_lat++;
    end
    check("ready_seen", {31'b0, ready}, 32'd1);
    r_err = err;
    r_rd  = RD;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'b0, ready}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; WE = 1'b0; RE = 1'b0; A = '0; WD = '0;
    for (int k = 0; k < N; k++) begin
      wait_cfg[k] = 0;
      s_rd[k*DW +: DW] = 32'hA000_0000 + k;
    end
    s_rd[2*DW +: DW] = 32'hDEAD_BEEF;
    s_rd[7*DW +: DW] = 32'h7777_0007;
    wait_cfg[3] = 3;
    wait_cfg[7] = 1;
    wait_cfg[1] = 1000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_rd",    RD,        32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_err",   {31'b0, err},   32'd0);
    check("rst_sel",   {24'b0, s_sel}, 32'd0);
    check("rst_we_re", {30'b0, s_we, s_re}, 32'd0);
    check("rst_wd",    s_wd,      32'd0);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: zero-wait read of slot 2
    exp_q.push_back(32'hDEAD_BEEF);
    run(1'b0, 1'b1, 6'h08, 32'h0);
    check("t1_lat", r_lat, 32'd2);
    check("t1_err", {31'b0, r_err}, 32'd0);
    check("t1_rd",  r_rd, exp_q.pop_front());
    check("t1_sel", {24'b0, r_sel}, 32'h04);
    check("t1_re_cycles", r_re, 32'd1);

    // 2: write slot 3 with three wait states
    run(1'b1, 1'b0, 6'h0C, 32'h1234);
    check("t2_lat", r_lat, 32'd5);
    check("t2_err", {31'b0, r_err}, 32'd0);
    check("t2_sel", {24'b0, r_sel}, 32'h08);
    check("t2_we_cycles", r_we, 32'd4);
    check("t2_re_cycles", r_re, 32'd0);
    check("t2_wd", s_wd, 32'h1234);
    check("t2_rd_kept", r_rd, 32'hDEAD_BEEF);

    // 3: unmapped read just past the last slot
    run(1'b0, 1'b1, 6'h20, 32'h0);
    check("t3_lat", r_lat, 32'd2);
    check("t3_err", {31'b0, r_err}, 32'd1);
    check("t3_rd",  r_rd, 32'd0);
    check("t3_strobes", {24'b0, r_sel} | r_we | r_re, 32'd0);
`ifdef PERIPH_BUS_ERRLOG_EN
    check("t3_log_code", {30'b0, err_code}, 32'd1);
    check("t3_log_addr", {26'b0, err_addr}, 32'h20);
`endif

    // 4: misaligned read
    run(1'b0, 1'b1, 6'h05, 32'h0);
    check("t4_lat", r_lat, 32'd2);
    check("t4_err", {31'b0, r_err}, 32'd1);
    check("t4_sel", {24'b0, r_sel}, 32'd0);
`ifdef PERIPH_BUS_ERRLOG_EN
    check("t4_log_sticky", {30'b0, err_code}, 32'd1);
`endif

    // one-wait read of slot 7
    exp_q.push_back(32'h7777_0007);
    run(1'b0, 1'b1, 6'h1C, 32'h0);
    check("r7_lat", r_lat, 32'd3);
    check("r7_rd",  r_rd, exp_q.pop_front());

    // WE and RE together: the write wins, RD untouched
    run(1'b1, 1'b1, 6'h00, 32'hCAFE);
    check("both_lat", r_lat, 32'd2);
    check("both_we",  r_we, 32'd1);
    check("both_re",  r_re, 32'd0);
    check("both_rd_kept", r_rd, 32'h7777_0007);

    // write to 4*N_SLOTS: log clear when enabled, unmapped otherwise
    run(1'b1, 1'b0, 6'h20, 32'h0);
`ifdef PERIPH_BUS_ERRLOG_EN
    check("clr_err", {31'b0, r_err}, 32'd0);
    check("clr_code", {30'b0, err_code}, 32'd0);
`else
    check("unmapped_wr_err", {31'b0, r_err}, 32'd1);
`endif
    check("unmapped_wr_rd_kept", r_rd, 32'h7777_0007);

    // 5: slot 1 never ready -> timeout after 15 ACCESS cycles
    run(1'b0, 1'b1, 6'h04, 32'h0);
    check("t5_lat", r_lat, 32'd16);
    check("t5_err", {31'b0, r_err}, 32'd1);
    check("t5_rd",  r_rd, 32'd0);
    check("t5_re_cycles", r_re, 32'd15);
    check("t5_sel", {24'b0, r_sel}, 32'h02);
`ifdef PERIPH_BUS_ERRLOG_EN
    check("t5_log_code", {30'b0, err_code}, 32'd3);
    check("t5_log_addr", {26'b0, err_addr}, 32'h04);
`endif

    // 6: reset in the middle of a wait-state write
    A = 6'h0C; WD = 32'h5555; WE = 1'b1;
    @(posedge clk); #1;
    WE = 1'b0;
    @(posedge clk); #1;
    check("t6_we_active", {31'b0, s_we}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_sel", {24'b0, s_sel}, 32'd0);
    check("t6_we",  {31'b0, s_we}, 32'd0);
    check("t6_state", {30'b0, fsm_state}, 32'd0);
    check("t6_wd", s_wd, 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        seen += int'(ready);
        @(posedge clk); #1;
      end
      check("t6_no_ready", seen, 32'd0);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    run(1'b0, 1'b1, 6'h08, 32'h0);
    check("t6_read_lat", r_lat, 32'd2);
    check("t6_read_rd", r_rd, exp_q.pop_front());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
